// File: rtl/dcache_victim_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_victim_drain_pkg
// Brief    : Shared line geometry and drain FSM encoding for the victim buffer.
// Revision : 1.0
// ============================================================================
package dcache_victim_drain_pkg;

    localparam int LINE_BITS      = 512;
    localparam int WORD_BITS      = 32;
    localparam int BEATS_PER_LINE = LINE_BITS / WORD_BITS;
    localparam int BEAT_W         = $clog2(BEATS_PER_LINE);
    localparam int LINE_OFFSET_W  = $clog2(LINE_BITS / 8);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/dcache_victim_drain_match.sv
`default_nettype none
// ============================================================================
// Module   : victim_match
// Brief    : Associative probe of the victim entries, newest matching entry wins.
// Revision : 1.0
// ============================================================================
module victim_match #(
    parameter int LA_W      = 26,
    parameter int DEPTH     = 4,
    parameter int LINE_BITS = 512,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                i_valid,
    input  logic [DEPTH-1:0][LA_W-1:0]      i_addrs,
    input  logic [DEPTH-1:0][LINE_BITS-1:0] i_lines,
    input  logic [PTR_W-1:0]                i_oldest,
    input  logic [LA_W-1:0]                 i_lookup_addr,
    output logic                            o_hit,
    output logic [LINE_BITS-1:0]            o_data
);

    // Walk from the oldest slot forward so a later (newer) match overrides.
    always_comb begin : p_match
        logic [PTR_W-1:0] w_idx;
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_oldest + PTR_W'(i);
            if (i_valid[w_idx] && (i_addrs[w_idx] == i_lookup_addr)) begin
                o_hit  = 1'b1;
                o_data = i_lines[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_victim_drain.sv
`default_nettype none
// ============================================================================
// Module   : dcache_victim_drain
// Brief    : Dirty-victim FIFO with lookup bypass, drained as 16-beat writes.
// Revision : 1.0
// ============================================================================
module dcache_victim_drain
    import dcache_victim_drain_pkg::*;
#(
    parameter  int TAG_WIDTH   = 20,
    parameter  int INDEX_WIDTH = 6,
    parameter  int DEPTH       = 4,
    localparam int LA_W        = TAG_WIDTH + INDEX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [LA_W-1:0]      push_addr,
    input  logic [LINE_BITS-1:0] push_data,
    input  logic [LA_W-1:0]      lookup_addr,
    output logic                 lookup_hit,
    output logic [LINE_BITS-1:0] lookup_data,
    output logic                 empty,
    output logic                 wr_req,
    input  logic                 wr_ready,
    output logic [31:0]          wr_addr,
    output logic                 wr_valid,
    input  logic                 wr_wready,
    output logic [31:0]          wr_data,
    output logic                 wr_last,
    input  logic                 wr_done
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0]                r_valid;
    logic [DEPTH-1:0][LA_W-1:0]      r_addr;
    logic [DEPTH-1:0][LINE_BITS-1:0] r_data;
    logic [PTR_W-1:0]                r_head;
    logic [PTR_W-1:0]                r_tail;
    logic [PTR_W:0]                  r_count;
    logic [BEAT_W-1:0]               r_beat;
    drain_state_e                    r_state;
    drain_state_e                    w_state_nxt;
    logic                            w_push;
    logic                            w_pop;
    logic [LA_W+LINE_OFFSET_W-1:0]   w_byte_addr;

    // Ready depends only on registered occupancy: a same-cycle pop never frees room.
    assign push_ready  = (r_count < (PTR_W + 1)'(DEPTH));
    assign empty       = (r_count == '0);
    assign w_push      = push_valid && push_ready;
    assign w_pop       = (r_state == ST_RESP) && wr_done;
    assign w_byte_addr = {r_addr[r_head], {LINE_OFFSET_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
            // Push and pop never target the same slot: that needs empty and full at once.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if ((r_state == ST_ADDR) && wr_ready) begin
                r_beat <= '0;
            end else if ((r_state == ST_DATA) && wr_wready) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= push_addr;
            r_data[r_tail] <= push_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        wr_last     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!empty) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                wr_req  = 1'b1;
                wr_addr = 32'(w_byte_addr);
                if (wr_ready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                wr_valid = 1'b1;
                wr_data  = r_data[r_head][WORD_BITS*r_beat +: WORD_BITS];
                wr_last  = (r_beat == BEAT_W'(BEATS_PER_LINE - 1));
                if (wr_wready && wr_last) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (wr_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    victim_match #(
        .LA_W      (LA_W),
        .DEPTH     (DEPTH),
        .LINE_BITS (LINE_BITS),
        .PTR_W     (PTR_W)
    ) u_victim_match (
        .i_valid       (r_valid),
        .i_addrs       (r_addr),
        .i_lines       (r_data),
        .i_oldest      (r_head),
        .i_lookup_addr (lookup_addr),
        .o_hit         (lookup_hit),
        .o_data        (lookup_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_dcache_victim_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_victim_drain
// Brief    : Directed self-checking bench for the victim drain buffer.
// Revision : 1.0
// ============================================================================
module tb_dcache_victim_drain;

    localparam int LA_W = 26;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    logic             push_ready;
    logic [LA_W-1:0]  push_addr;
    logic [511:0]     push_data;
    logic [LA_W-1:0]  lookup_addr;
    logic             lookup_hit;
    logic [511:0]     lookup_data;
    logic             empty;
    logic             wr_req;
    logic             wr_ready;
    logic [31:0]      wr_addr;
    logic             wr_valid;
    logic             wr_wready;
    logic [31:0]      wr_data;
    logic             wr_last;
    logic             wr_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_victim_drain #(
        .TAG_WIDTH   (20),
        .INDEX_WIDTH (6),
        .DEPTH       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_addr   (push_addr),
        .push_data   (push_data),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .empty       (empty),
        .wr_req      (wr_req),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_valid    (wr_valid),
        .wr_wready   (wr_wready),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_done     (wr_done)
    );

    function automatic logic [511:0] make_line(input logic [31:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = seed + 32'(k);
        return l;
    endfunction

    task automatic do_push(input logic [LA_W-1:0] a, input logic [511:0] d);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    // Plays the memory side for one line and records what it saw.
    task automatic drain_capture(input bit stall_mode, input bit send_done,
                                 output logic [31:0] addr, output logic [511:0] line,
                                 output int beats, output logic [15:0] lastpos,
                                 output int unstable);
        int n;
        bit stalled;
        bit go;
        logic [31:0] pd;
        logic pl;
        addr = '0; line = '0; beats = 0; lastpos = '0; unstable = 0;
        stalled = 1'b0; pd = '0; pl = 1'b0;
        n = 0;
        while (!wr_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        addr = wr_addr;
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        n = 0;
        while (beats < 16 && n < 400) begin
            if (stalled && (wr_data !== pd || wr_last !== pl)) unstable++;
            go = stall_mode ? 1'($urandom_range(1, 0)) : 1'b1;
            wr_wready = go;
            pd = wr_data;
            pl = wr_last;
            stalled = wr_valid && !go;
            if (wr_valid && go) begin
                line[32*beats +: 32] = wr_data;
                lastpos[beats] = wr_last;
                beats++;
            end
            @(negedge clk);
            n++;
        end
        wr_wready = 1'b0;
        if (send_done) begin
            wr_done = 1'b1;
            @(negedge clk);
            wr_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
        lookup_addr = '0; wr_ready = 1'b0; wr_wready = 1'b0; wr_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL rst_push_ready got %b want 1", push_ready); end
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL rst_lookup_hit got %b want 0", lookup_hit); end
        n_checks++; if (lookup_data !== '0) begin n_fail++; $display("FAIL rst_lookup_data got %h want 0", lookup_data); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
        n_checks++; if ({wr_req, wr_valid, wr_last} !== 3'b000) begin n_fail++; $display("FAIL rst_wr_ctrl got %b want 000", {wr_req, wr_valid, wr_last}); end
        n_checks++; if (wr_addr !== 32'h0) begin n_fail++; $display("FAIL rst_wr_addr got %h want 0", wr_addr); end
        n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [LA_W-1:0] a;
        logic [511:0] d, got;
        logic [31:0] ga;
        logic [15:0] lp;
        int nb, us;
        a = 26'h0123456;
        d = make_line(32'h0);
        do_push(a, d);
        lookup_addr = a;
        #1;
        n_checks++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit got %b want 1", lookup_hit); end
        n_checks++; if (lookup_data !== d) begin n_fail++; $display("FAIL basic_lookup_data got %h want %h", lookup_data[63:0], d[63:0]); end
        drain_capture(1'b0, 1'b1, ga, got, nb, lp, us);
        n_checks++; if (ga !== 32'h048D1580) begin n_fail++; $display("FAIL basic_wr_addr got %h want 048d1580", ga); end
        n_checks++; if (nb !== 16) begin n_fail++; $display("FAIL basic_beats got %0d want 16", nb); end
        n_checks++; if (got !== d) begin n_fail++; $display("FAIL basic_wr_data got %h want %h", got[63:0], d[63:0]); end
        n_checks++; if (lp !== 16'h8000) begin n_fail++; $display("FAIL basic_wr_last got %h want 8000", lp); end
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after got %b want 1", empty); end
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL basic_hit_after got %b want 0", lookup_hit); end
    endtask

    task automatic test_full();
        logic [LA_W-1:0] base;
        logic [LA_W-1:0] ea;
        logic [511:0] got;
        logic [31:0] ga;
        logic [15:0] lp;
        int nb, us;
        base = 26'h0100000;
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_push(base + LA_W'(i), make_line(32'h100 * (i + 1)));
        #1;
        n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_push_ready got %b want 0", push_ready); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b want 0", empty); end
        push_valid = 1'b1; push_addr = base + 26'd4; push_data = make_line(32'h500);
        repeat (3) @(negedge clk);
        push_valid = 1'b0;
        lookup_addr = base + 26'd4;
        #1;
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL full_fifth_held_off got %b want 0", lookup_hit); end
        lookup_addr = base + 26'd3;
        #1;
        n_checks++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL full_fourth_visible got %b want 1", lookup_hit); end
        for (int i = 0; i < 4; i++) begin
            drain_capture(1'b0, 1'b1, ga, got, nb, lp, us);
            ea = base + LA_W'(i);
            #1;
            if (i == 0) begin
                n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b want 1", push_ready); end
            end
            n_checks++; if (ga !== {ea, 6'b0}) begin n_fail++; $display("FAIL full_order_addr%0d got %h want %h", i, ga, {ea, 6'b0}); end
            n_checks++; if (got !== make_line(32'h100 * (i + 1))) begin n_fail++; $display("FAIL full_order_data%0d got %h", i, got[63:0]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_empty_end got %b want 1", empty); end
    endtask

    task automatic test_duplicate();
        logic [LA_W-1:0] a;
        logic [511:0] x, y, got;
        logic [31:0] ga;
        logic [15:0] lp;
        int nb, us;
        a = 26'h1555555;
        x = make_line(32'hA000);
        y = make_line(32'hB000);
        do_push(a, x);
        do_push(a, y);
        lookup_addr = a;
        #1;
        n_checks++; if (lookup_data !== y) begin n_fail++; $display("FAIL dup_newest got %h want %h", lookup_data[63:0], y[63:0]); end
        drain_capture(1'b0, 1'b1, ga, got, nb, lp, us);
        n_checks++; if (got !== x) begin n_fail++; $display("FAIL dup_first_drain got %h want %h", got[63:0], x[63:0]); end
        #1;
        n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== y) begin n_fail++; $display("FAIL dup_mid_lookup hit %b data %h want 1 %h", lookup_hit, lookup_data[63:0], y[63:0]); end
        drain_capture(1'b0, 1'b1, ga, got, nb, lp, us);
        n_checks++; if (got !== y) begin n_fail++; $display("FAIL dup_second_drain got %h want %h", got[63:0], y[63:0]); end
        #1;
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL dup_hit_after got %b want 0", lookup_hit); end
    endtask

    task automatic test_stall();
        logic [511:0] d, got;
        logic [31:0] ga;
        logic [15:0] lp;
        int nb, us;
        for (int r = 0; r < 2; r++) begin
            d = make_line(32'hC0DE0000 + 32'(r * 16'h100));
            do_push(26'h3FFFFFF, d);
            drain_capture(1'b1, 1'b1, ga, got, nb, lp, us);
            n_checks++; if (us !== 0) begin n_fail++; $display("FAIL stall_stable%0d got %0d changes want 0", r, us); end
            n_checks++; if (nb !== 16) begin n_fail++; $display("FAIL stall_beats%0d got %0d want 16", r, nb); end
            n_checks++; if (got !== d) begin n_fail++; $display("FAIL stall_data%0d got %h want %h", r, got[63:0], d[63:0]); end
            n_checks++; if (lp !== 16'h8000) begin n_fail++; $display("FAIL stall_last%0d got %h want 8000", r, lp); end
            n_checks++; if (ga !== 32'hFFFFFFC0) begin n_fail++; $display("FAIL stall_addr%0d got %h want ffffffc0", r, ga); end
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] d, got;
        logic [31:0] ga;
        logic [15:0] lp;
        int nb, us, n, reqs;
        do_push(26'h0000001, make_line(32'h5000));
        n = 0;
        while (!wr_req && n < 50) begin @(negedge clk); n++; end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        wr_wready = 1'b1;
        repeat (7) @(negedge clk);
        wr_wready = 1'b0;
        #1;
        n_checks++; if (wr_data !== 32'h5007) begin n_fail++; $display("FAIL rmid_beat7 got %h want 00005007", wr_data); end
        rst = 1'b1;
        lookup_addr = 26'h0000001;
        @(negedge clk);
        #1;
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_valid got %b want 0", wr_valid); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty got %b want 1", empty); end
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL rmid_hit got %b want 0", lookup_hit); end
        rst = 1'b0;
        @(negedge clk);
        d = make_line(32'h6000);
        do_push(26'h0ABCDEF, d);
        drain_capture(1'b0, 1'b1, ga, got, nb, lp, us);
        n_checks++; if (ga !== 32'h2AF37BC0) begin n_fail++; $display("FAIL rmid_new_addr got %h want 2af37bc0", ga); end
        n_checks++; if (got !== d || nb !== 16) begin n_fail++; $display("FAIL rmid_new_data got %h beats %0d want %h 16", got[63:0], nb, d[63:0]); end
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wr_req) reqs++;
        end
        n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL rmid_no_resend got %0d requests want 0", reqs); end
    endtask

    task automatic test_full_push_pop();
        logic [LA_W-1:0] base, e, ea;
        logic [511:0] got;
        logic [31:0] ga;
        logic [15:0] lp;
        int nb, us;
        base = 26'h0200000;
        e = 26'h0300000;
        for (int i = 0; i < 4; i++) do_push(base + LA_W'(i), make_line(32'h7000 + 32'(i * 16'h100)));
        drain_capture(1'b0, 1'b0, ga, got, nb, lp, us);
        n_checks++; if (ga !== {base, 6'b0}) begin n_fail++; $display("FAIL fpp_first_addr got %h want %h", ga, {base, 6'b0}); end
        push_valid = 1'b1; push_addr = e; push_data = make_line(32'hE000);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        lookup_addr = e;
        #1;
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL fpp_not_taken got %b want 0", lookup_hit); end
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL fpp_ready_next got %b want 1", push_ready); end
        @(negedge clk);
        push_valid = 1'b0;
        #1;
        n_checks++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL fpp_taken got %b want 1", lookup_hit); end
        n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL fpp_full_again got %b want 0", push_ready); end
        for (int i = 0; i < 4; i++) begin
            drain_capture(1'b0, 1'b1, ga, got, nb, lp, us);
            ea = (i == 3) ? e : base + LA_W'(i + 1);
            n_checks++; if (ga !== {ea, 6'b0}) begin n_fail++; $display("FAIL fpp_order%0d got %h want %h", i, ga, {ea, 6'b0}); end
        end
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty_end got %b want 1", empty); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_duplicate();
        test_stall();
        test_reset_mid();
        test_full_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
